// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: parses UART command frames into card_driver write/read requests and reports one status byte per command
// Ports: CLOCK50/RESET clock and async active-high reset; RX_STB/RX_DAT received UART bytes;
// WR_* write request, WD_* seeded incrementing write-data stream; RD_* read request;
// RES_STB read result byte monitor; ST_* status byte handshake; BUSY high outside IDLE.
module sd_cmd_sequencer #(
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int CNT_W = 24
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    output logic [7:0]  WR_LENGTH,
    input  logic        WR_ACK,
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    output logic [7:0]  RD_LENGTH,
    input  logic        RD_ACK,
    input  logic        RES_STB,
    output logic        ST_STB,
    output logic [7:0]  ST_DAT,
    input  logic        ST_ACK,
    output logic        BUSY
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [3:0] {IDLE, GET_ADDR, GET_LEN, GET_SEED, REQ_WR, WR_DATA, REQ_RD, RD_DATA, STATUS} state_t;
    state_t state;
    logic is_wr;
    logic [1:0] nb;
    logic [31:0] addr;
    logic [7:0] len;
    logic [CNT_W-1:0] cnt, cnt_inc, total;
    logic [TW-1:0] tmo;
    logic tmo_hit, last;
    assign total = (CNT_W'(len) + CNT_W'(1)) * CNT_W'(BLOCK_BYTES);
    assign cnt_inc = cnt + CNT_W'(1);
    assign last = cnt_inc == total;
    assign tmo_hit = tmo == TW'(TIMEOUT_CYC - 1);
    assign WR_ADDR = addr;
    assign RD_ADDR = addr;
    assign WR_LENGTH = len;
    assign RD_LENGTH = len;
    assign BUSY = state != IDLE;
    // WD_DATA is loaded with the seed as soon as it arrives and then counts up per accepted beat.
    // A data beat that completes the transfer is checked before the timeout so completion wins a tie.
    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            is_wr   <= 1'b0;
            nb      <= '0;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            tmo     <= '0;
            WR_STB  <= 1'b0;
            WD_STB  <= 1'b0;
            WD_DATA <= '0;
            RD_STB  <= 1'b0;
            ST_STB  <= 1'b0;
            ST_DAT  <= '0;
        end else begin
            case (state)
                IDLE: if (RX_STB) begin
                    tmo   <= '0;
                    nb    <= '0;
                    is_wr <= RX_DAT == "W";
                    if (RX_DAT == "W" || RX_DAT == "R") state <= GET_ADDR;
                    else begin
                        state  <= STATUS;
                        ST_STB <= 1'b1;
                        ST_DAT <= "?";
                    end
                end
                GET_ADDR, GET_LEN, GET_SEED: begin
                    if (RX_STB) begin
                        tmo <= '0;
                        case (state)
                            GET_ADDR: begin
                                addr <= {addr[23:0], RX_DAT};
                                nb   <= nb + 2'd1;
                                if (nb == 2'd3) state <= GET_LEN;
                            end
                            GET_LEN: begin
                                len <= RX_DAT;
                                if (is_wr) state <= GET_SEED;
                                else begin
                                    state  <= REQ_RD;
                                    RD_STB <= 1'b1;
                                end
                            end
                            default: begin
                                WD_DATA <= RX_DAT;
                                state   <= REQ_WR;
                                WR_STB  <= 1'b1;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        state  <= STATUS;
                        ST_STB <= 1'b1;
                        ST_DAT <= "T";
                    end else tmo <= tmo + TW'(1);
                end
                REQ_WR: if (WR_ACK) begin
                    WR_STB <= 1'b0;
                    WD_STB <= 1'b1;
                    cnt    <= '0;
                    tmo    <= '0;
                    state  <= WR_DATA;
                end
                WR_DATA: begin
                    if (WD_ACK) begin
                        cnt     <= cnt_inc;
                        WD_DATA <= WD_DATA + 8'd1;
                        tmo     <= '0;
                        if (last) begin
                            WD_STB <= 1'b0;
                            state  <= STATUS;
                            ST_STB <= 1'b1;
                            ST_DAT <= "K";
                        end
                    end else if (tmo_hit) begin
                        WD_STB <= 1'b0;
                        state  <= STATUS;
                        ST_STB <= 1'b1;
                        ST_DAT <= "E";
                    end else tmo <= tmo + TW'(1);
                end
                REQ_RD: if (RD_ACK) begin
                    RD_STB <= 1'b0;
                    cnt    <= '0;
                    tmo    <= '0;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    if (RES_STB) begin
                        cnt <= cnt_inc;
                        tmo <= '0;
                        if (last) begin
                            state  <= STATUS;
                            ST_STB <= 1'b1;
                            ST_DAT <= "K";
                        end
                    end else if (tmo_hit) begin
                        state  <= STATUS;
                        ST_STB <= 1'b1;
                        ST_DAT <= "E";
                    end else tmo <= tmo + TW'(1);
                end
                STATUS: if (ST_ACK) begin
                    ST_STB <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed table-driven bench for sd_cmd_sequencer with BLOCK_BYTES=4, TIMEOUT_CYC=100
module tb_sd_cmd_sequencer;
    logic        CLOCK50 = 1'b0, RESET = 1'b1;
    logic        RX_STB = 1'b0, WR_ACK = 1'b0, WD_ACK = 1'b0, RD_ACK = 1'b0, RES_STB = 1'b0, ST_ACK = 1'b0;
    logic [7:0]  RX_DAT = '0;
    logic        WR_STB, WD_STB, RD_STB, ST_STB, BUSY;
    logic [31:0] WR_ADDR, RD_ADDR;
    logic [7:0]  WR_LENGTH, RD_LENGTH, WD_DATA, ST_DAT;
    int errors = 0, checks = 0, n;
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  seed;
        int          dly;
        logic [7:0]  exp;
    } cmd_t;
    cmd_t tbl[5];
    sd_cmd_sequencer #(.BLOCK_BYTES(4), .TIMEOUT_CYC(100), .CNT_W(12)) dut (
        .CLOCK50(CLOCK50), .RESET(RESET), .RX_STB(RX_STB), .RX_DAT(RX_DAT),
        .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_LENGTH(WR_LENGTH), .WR_ACK(WR_ACK),
        .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
        .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_LENGTH(RD_LENGTH), .RD_ACK(RD_ACK),
        .RES_STB(RES_STB), .ST_STB(ST_STB), .ST_DAT(ST_DAT), .ST_ACK(ST_ACK), .BUSY(BUSY)
    );
    always #10 CLOCK50 = ~CLOCK50;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic tick;
        @(negedge CLOCK50);
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        RX_STB = 1'b1;
        RX_DAT = b;
        tick;
        RX_STB = 1'b0;
    endtask
    task automatic send_frame(input cmd_t c);
        send(c.op);
        for (int i = 3; i >= 0; i--) send(c.addr[i*8 +: 8]);
        send(c.len);
        if (c.op == "W") send(c.seed);
    endtask
    task automatic wr_handshake;
        WR_ACK = 1'b1;
        tick;
        WR_ACK = 1'b0;
    endtask
    task automatic wait_st(output int cyc);
        cyc = 0;
        while (!ST_STB && cyc < 200) begin
            tick;
            cyc++;
        end
    endtask
    task automatic ack_status;
        ST_ACK = 1'b1;
        tick;
        ST_ACK = 1'b0;
        chk("st_stb_drop", {31'd0, ST_STB}, 0);
        chk("busy_after_ack", {31'd0, BUSY}, 0);
    endtask
    task automatic run_cmd(input cmd_t c);
        int total;
        total = (c.len + 1) * 4;
        chk("busy_idle", {31'd0, BUSY}, 0);
        if (c.op == "W") begin
            send_frame(c);
            chk("wr_stb", {31'd0, WR_STB}, 1);
            chk("wr_addr", WR_ADDR, c.addr);
            chk("wr_len", {24'd0, WR_LENGTH}, {24'd0, c.len});
            for (int i = 0; i < c.dly; i++) begin
                tick;
                chk("wr_stb_hold", {31'd0, WR_STB}, 1);
            end
            wr_handshake;
            chk("wr_stb_after_ack", {31'd0, WR_STB}, 0);
            for (int i = 0; i < total; i++) begin
                chk("wd_stb", {31'd0, WD_STB}, 1);
                chk("wd_data", {24'd0, WD_DATA}, {24'd0, 8'(c.seed + i)});
                WD_ACK = 1'b1;
                tick;
            end
            WD_ACK = 1'b0;
            chk("wd_stb_end", {31'd0, WD_STB}, 0);
        end else if (c.op == "R") begin
            send_frame(c);
            chk("rd_stb", {31'd0, RD_STB}, 1);
            chk("rd_addr", RD_ADDR, c.addr);
            chk("rd_len", {24'd0, RD_LENGTH}, {24'd0, c.len});
            for (int i = 0; i < c.dly; i++) begin
                tick;
                chk("rd_stb_hold", {31'd0, RD_STB}, 1);
            end
            RD_ACK = 1'b1;
            tick;
            RD_ACK = 1'b0;
            chk("rd_stb_after_ack", {31'd0, RD_STB}, 0);
            for (int i = 0; i < total; i++) begin
                chk("st_early", {31'd0, ST_STB}, 0);
                RES_STB = 1'b1;
                tick;
                RES_STB = 1'b0;
                tick;
            end
        end else send(c.op);
        chk("busy_status", {31'd0, BUSY}, 1);
        chk("st_stb", {31'd0, ST_STB}, 1);
        chk("st_dat", {24'd0, ST_DAT}, {24'd0, c.exp});
        ack_status;
    endtask
    initial begin
        cmd_t c;
        tbl[0] = '{"W", 32'h0000_0001, 8'h01, 8'h41, 1, "K"};
        tbl[1] = '{"R", 32'h1234_5678, 8'h00, 8'h00, 3, "K"};
        tbl[2] = '{"x", 32'h0, 8'h00, 8'h00, 0, "?"};
        tbl[3] = '{"W", 32'hDEAD_BEEF, 8'h00, 8'hFE, 0, "K"};
        tbl[4] = '{"R", 32'hA5A5_0001, 8'h02, 8'h00, 0, "K"};
        tick;
        chk("reset_strobes", {27'd0, WR_STB, WD_STB, RD_STB, ST_STB, BUSY}, 0);
        chk("reset_st_dat", {24'd0, ST_DAT}, 0);
        RESET = 1'b0;
        tick;
        foreach (tbl[k]) run_cmd(tbl[k]);
        // parse timeout after 'W',00 then a normal read
        send("W");
        send(8'h00);
        wait_st(n);
        chk("parse_tmo_cycles", n, 100);
        chk("parse_tmo_dat", {24'd0, ST_DAT}, {24'd0, 8'h54});
        ack_status;
        run_cmd('{"R", 32'h0000_00AA, 8'h00, 8'h00, 0, "K"});
        // data stall after 2 of 4 bytes
        c = '{"W", 32'h0, 8'h00, 8'h10, 0, "E"};
        send_frame(c);
        wr_handshake;
        WD_ACK = 1'b1;
        tick;
        tick;
        WD_ACK = 1'b0;
        wait_st(n);
        chk("stall_cycles", n, 100);
        chk("stall_wd_stb", {31'd0, WD_STB}, 0);
        chk("stall_dat", {24'd0, ST_DAT}, {24'd0, 8'h45});
        ack_status;
        // last byte accepted on the very cycle the timeout would fire
        c = '{"W", 32'h0, 8'h00, 8'h00, 0, "K"};
        send_frame(c);
        wr_handshake;
        WD_ACK = 1'b1;
        repeat (3) tick;
        WD_ACK = 1'b0;
        repeat (99) tick;
        chk("tie_pre_wd_stb", {31'd0, WD_STB}, 1);
        WD_ACK = 1'b1;
        tick;
        WD_ACK = 1'b0;
        chk("tie_wd_stb", {31'd0, WD_STB}, 0);
        chk("tie_dat", {24'd0, ST_DAT}, {24'd0, 8'h4B});
        ack_status;
        // reset during the third byte of a wrapping write
        c = '{"W", 32'h0000_0100, 8'h00, 8'hFE, 0, "K"};
        send_frame(c);
        wr_handshake;
        WD_ACK = 1'b1;
        tick;
        tick;
        WD_ACK = 1'b0;
        chk("wrap_third", {24'd0, WD_DATA}, 32'h00);
        RESET = 1'b1;
        #1;
        chk("mid_reset_strobes", {27'd0, WR_STB, WD_STB, RD_STB, ST_STB, BUSY}, 0);
        chk("mid_reset_data", {WD_DATA, ST_DAT, WR_LENGTH, 8'd0}, 0);
        chk("mid_reset_addr", WR_ADDR, 0);
        tick;
        RESET = 1'b0;
        repeat (5) tick;
        chk("post_reset_no_status", {30'd0, ST_STB, BUSY}, 0);
        run_cmd('{"x", 32'h0, 8'h00, 8'h00, 0, "?"});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
UART-driven command sequencer for card_driver on CLOCK50. It parses framed command bytes from the UART receiver into write and read requests, holds the WR/RD strobes until card_driver accepts them, and sources a seeded incrementing write-data stream on the WD interface. It counts read-result bytes on RES_STB and returns a one-byte status per command on a strobe/ack port that feeds the UART transmit path.

Parameters:
BLOCK_BYTES, 512, data bytes per length unit; total transfer = (LEN+1)*BLOCK_BYTES.
TIMEOUT_CYC, 5000000, maximum idle gap in CLOCK50 cycles between command bytes and between data beats (100 ms).
CNT_W, 24, width of the byte counter; must satisfy 2^CNT_W > 256*BLOCK_BYTES.

Ports:
CLOCK50  in  1  system clock
RESET  in  1  reset
RX_STB  in  1  one-cycle pulse: received UART byte valid
RX_DAT  in  8  received UART byte
WR_STB  out  1  write request to card_driver
WR_ADDR  out  32  write start address
WR_LENGTH  out  8  write length (LEN)
WR_ACK  in  1  write request accepted
WD_STB  out  1  write data valid
WD_DATA  out  8  write data byte
WD_ACK  in  1  write data byte taken this cycle
RD_STB  out  1  read request to card_driver
RD_ADDR  out  32  read start address
RD_LENGTH  out  8  read length (LEN)
RD_ACK  in  1  read request accepted
RES_STB  in  1  read result byte strobe (monitor only)
ST_STB  out  1  status byte valid
ST_DAT  out  8  status byte
ST_ACK  in  1  status byte taken
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: RESET, asynchronous, active-high; clock CLOCK50. All outputs are 0 in reset; state is IDLE; counters are cleared.
- Command frames (address MSB first):
  - Write: 'W', A3, A2, A1, A0, LEN, SEED.
  - Read: 'R', A3, A2, A1, A0, LEN.
- Any other first byte in IDLE: status '?'.
- States:
  - IDLE: on an RX_STB with 'W' or 'R', go to GET_ADDR.
  - GET_ADDR: collect 4 bytes into the address shift register, then go to GET_LEN.
  - GET_LEN: for a write, go to GET_SEED; for a read, go to REQ_RD.
  - GET_SEED: store the seed, then go to REQ_WR.
  - REQ_WR: WR_STB=1 with WR_ADDR/WR_LENGTH stable. On the cycle WR_ACK=1 is sampled, WR_STB drops the next cycle and the state moves to WR_DATA.
  - WR_DATA:
    - WD_STB=1 and WD_DATA starts at SEED.
    - Each cycle with WD_ACK=1 transfers one byte; WD_DATA increments mod 256 on the next cycle; the counter increments.
    - When the count reaches (LEN+1)*BLOCK_BYTES, WD_STB drops the same clock edge as the last accepted byte and the state moves to STATUS with 'K'.
  - REQ_RD: same handshake as REQ_WR, using RD_STB/RD_ACK, then go to RD_DATA.
  - RD_DATA: count RES_STB pulses; on reaching (LEN+1)*BLOCK_BYTES, go to STATUS with 'K'.
  - STATUS: ST_STB=1 with ST_DAT held until ST_ACK=1 is sampled; drop ST_STB the next cycle; return to IDLE.
- Length arithmetic: total bytes = ({1'b0,LEN}+1)*BLOCK_BYTES, computed at CNT_W width without overflow. LEN=255 is legal.
- Timeouts: a counter resets on every RX_STB in parse states and on every WD_ACK/RES_STB in data states.
  - In GET_ADDR/GET_LEN/GET_SEED, reaching TIMEOUT_CYC goes to STATUS with 'T'.
  - In WR_DATA/RD_DATA, reaching TIMEOUT_CYC goes to STATUS with 'E' and clears WD_STB.
  - No timeout in REQ_WR, REQ_RD or STATUS; these wait indefinitely.
- RX_STB outside IDLE and the parse states is ignored: no buffering, no status.
- RES_STB outside RD_DATA is ignored. WD_ACK while WD_STB=0 is ignored.
- Simultaneous WD_ACK on the last byte and a timeout on the same cycle: the completion wins and the status is 'K'.
- Status bytes are serialised: only one is pending at a time, and no new command is parsed until ST_ACK.
- RESET mid-operation aborts immediately, with all strobes low and no status emitted.

Test Plan:
- Write, sim BLOCK_BYTES=4: RX 'W',00,00,00,01,01,41, WR_ACK one cycle after WR_STB, WD_ACK held high -> WR_ADDR=1, WR_LENGTH=1; 8 WD bytes 41..48; WD_STB low after the 8th ack; ST_DAT='K'.
- Read: RX 'R',12,34,56,78,00, RD_ACK after 3 cycles, then 4 RES_STB pulses -> RD_STB high exactly until the ack; RD_ADDR=0x12345678; 'K' after the 4th pulse; BUSY low after ST_ACK.
- Bad opcode: RX 'x' -> ST_DAT='?'; BUSY pulses high only for the STATUS duration.
- Parse timeout, TIMEOUT_CYC=100: RX 'W',00 then silence -> 'T' at 100 cycles; a following valid 'R' frame completes normally.
- Data stall: write with LEN=0 where WD_ACK stops after 2 bytes -> 'E' after TIMEOUT_CYC cycles; WD_STB low.
- Wrap and reset: SEED=FE, LEN=0 -> data FE,FF,00,01. Assert RESET during the 3rd byte -> all outputs 0 in the same cycle; no status.
